fetch_pc_unit: RTL
==================

# fetch_pc_unit

Program-counter and fetch-control stage sitting directly upstream of the instruction memory. It holds the byte-addressed PC and drives the word address into the instruction memory's `read_addr`. It selects the next PC from sequential, branch or jump sources, and stops fetch on ECALL/EBREAK (halt) or an illegal fetch target (trap). It also keeps a retired-fetch counter for the testbench and debug.

## Interface
- `RESET_PC`, default 32'h0000_0000: byte PC loaded on reset; must be word-aligned.
- `IMEM_WORDS`, default 64: instruction memory depth in words; legal byte PCs are 0 .. 4*IMEM_WORDS-4.

- `clk`  in  1: rising-edge clock.
- `reset`  in  1: reset, synchronous, active-high.
- `stall`  in  1: hold PC this cycle; any redirect presented is ignored.
- `branch_taken`  in  1: redirect to `branch_target`.
- `branch_target`  in  32: byte address.
- `jump`  in  1: redirect to `jump_target`.
- `jump_target`  in  32: byte address.
- `instruction`  in  32: current word returned by the instruction memory for `read_addr`.
- `pc`  out  32: current byte PC (registered).
- `read_addr`  out  32: `{2'b00, pc[31:2]}`, the word address to the instruction memory.
- `pc_plus4`  out  32: `pc + 4`, modulo 2^32.
- `fetch_valid`  out  1: `instruction` is consumed this cycle.
- `halted`  out  1: state is HALT.
- `trapped`  out  1: state is TRAP.
- `fault_addr`  out  32: offending next-PC that caused TRAP.
- `instret`  out  32: count of consumed fetches.

## Operation
- States: RUN, HALT, TRAP. Reset enters RUN.
- `fetch_valid = (state==RUN) & ~stall & ~reset`.
- Candidate next PC, by priority:
  1. `jump` selects `jump_target`.
  2. Otherwise `branch_taken` selects `branch_target`.
  3. Otherwise `pc_plus4`.
- Halt detect: `instruction` equals 32'h0000_0073 (ECALL) or 32'h0010_0073 (EBREAK).
- RUN with `stall=1`:
  - pc, state and `instret` hold.
  - Redirect inputs are dropped; the upstream must re-present them.
- RUN, `stall=0`, halt detected:
  - Go to HALT; pc holds at the ECALL/EBREAK address.
  - `instret` increments.
  - Redirects are ignored.
- RUN, `stall=0`, candidate illegal:
  - Illegal means `cand[1:0]!=0` or `cand >= 4*IMEM_WORDS` (unsigned).
  - Go to TRAP; pc holds; `fault_addr <= cand`; `instret` increments.
  - Sequential run-off past the last word traps the same way, since `pc_plus4` is out of range.
  - A `pc_plus4` that wraps to 0 at 32'hFFFF_FFFC is unreachable, because range is checked first.
- RUN, `stall=0`, otherwise: `pc <= cand`; `instret <= instret + 1`.
- HALT and TRAP are sticky.
  - All inputs are ignored.
  - Only `reset` exits.
- `instret` wraps modulo 2^32.
- `fault_addr` is written only on entry to TRAP.
- Priority overall: reset > halt detect > illegal target > normal update. Stall gates all of these except reset.

## Timing
- Reset values, on the first edge with `reset=1`:
  - `pc=RESET_PC`, `read_addr=RESET_PC>>2`, `pc_plus4=RESET_PC+4`.
  - `halted=0`, `trapped=0`, `fault_addr=0`, `instret=0`, state RUN.
  - `fetch_valid=0` while `reset` is high.
- Reset asserted mid-operation, in any state, wins at that edge; in-flight redirects are discarded.
- `pc`, state, `fault_addr` and `instret` change only on the rising edge.
- `read_addr`, `pc_plus4` and `fetch_valid` are combinational from registers, `stall` and `reset`.
- `halted` and `trapped` are decoded from the state register, with no extra cycle.
- Latency:
  - A redirect sampled at edge N drives `read_addr` from edge N onward, so the new instruction appears in cycle N+1.
  - No branch delay slot; no bubble is inserted by this block.
- `instruction` must be valid in the same cycle as `read_addr`; the instruction memory read is combinational.
- `jump` and `branch_taken` both high: the jump wins, and the branch is not evaluated for legality.

## Test plan
- Sequential fetch:
  - Stimulus: reset for 1 cycle, then 5 cycles of NOP (32'h0000_0013), no stall.
  - Required: `pc` = 0,4,8,12,16,20; `read_addr` = 0..5; `instret`=5.
- Redirect priority:
  - Stimulus: at pc=8, assert `jump=1`/`jump_target=40` and `branch_taken=1`/`branch_target=100` together.
  - Required: next `pc=40`, `read_addr=10`.
  - Follow-up: `branch_target=24` alone gives `pc=24`.
- Stall:
  - Stimulus: at pc=12, hold `stall=1` for 3 cycles with `jump=1`/`jump_target=0` asserted.
  - Required: `pc` stays 12, `fetch_valid=0`, `instret` unchanged.
  - After release with no redirect: `pc=16`.
- Halt:
  - Stimulus: `instruction=32'h0000_0073` at pc=20.
  - Required: `halted=1` next cycle, `pc` stays 20, `fetch_valid=0`; later `jump` is ignored.
  - Reset then restores `pc=0`, `halted=0`.
- Traps:
  - `branch_target=6` gives `trapped=1`, `fault_addr=6`, `pc` unchanged.
  - Separately, fetch at pc=252 with IMEM_WORDS=64 gives `trapped=1`, `fault_addr=256`.
- Reset mid-run:
  - Stimulus: `reset=1` for one edge while in TRAP with `instret=7`.
  - Required: state RUN, `pc=RESET_PC`, `instret=0`, `fault_addr=0`.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bus: redirect/stall controls and the instruction word in,
// PC, fetch status and counters out.
interface fetch_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] read_addr;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        halted;
    logic        trapped;
    logic [31:0] fault_addr;
    logic [31:0] instret;

    modport master (
        output stall, branch_taken, branch_target, jump, jump_target, instruction,
        input  pc, read_addr, pc_plus4, fetch_valid, halted, trapped, fault_addr, instret
    );

    modport slave (
        input  stall, branch_taken, branch_target, jump, jump_target, instruction,
        output pc, read_addr, pc_plus4, fetch_valid, halted, trapped, fault_addr, instret
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter and fetch control: selects the next PC, drives the
// instruction memory word address, and stops on ECALL/EBREAK or bad targets.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64
) (
    input  logic    clk,
    input  logic    reset,
    fetch_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        TRAP = 2'd2
    } state_t;

    localparam logic [31:0] ECALL    = 32'h0000_0073;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;
    localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) << 2;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic [31:0] instret_q, instret_d;
    logic        halted_q, trapped_q;

    logic [31:0] pc_plus4;
    logic [31:0] cand;
    logic        halt_hit;
    logic        illegal;

    assign pc_plus4 = pc_q + 32'd4;

    // Jump outranks branch, so a simultaneous bad branch target never traps.
    always_comb begin
        cand     = bus.jump ? bus.jump_target
                 : (bus.branch_taken ? bus.branch_target : pc_plus4);
        halt_hit = (bus.instruction == ECALL) || (bus.instruction == EBREAK);
        illegal  = (cand[1:0] != 2'b00) || ({1'b0, cand} >= PC_LIMIT);

        state_d      = state_q;
        pc_d         = pc_q;
        fault_addr_d = fault_addr_q;
        instret_d    = instret_q;

        if (reset) begin
            state_d      = RUN;
            pc_d         = RESET_PC;
            fault_addr_d = 32'd0;
            instret_d    = 32'd0;
        end else if (state_q == RUN && !bus.stall) begin
            instret_d = instret_q + 32'd1;
            if (halt_hit) begin
                state_d = HALT;
            end else if (illegal) begin
                state_d      = TRAP;
                fault_addr_d = cand;
            end else begin
                pc_d = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        state_q      <= state_d;
        pc_q         <= pc_d;
        fault_addr_q <= fault_addr_d;
        instret_q    <= instret_d;
        halted_q     <= (state_d == HALT);
        trapped_q    <= (state_d == TRAP);
    end

    assign bus.pc          = pc_q;
    assign bus.read_addr   = {2'b00, pc_q[31:2]};
    assign bus.pc_plus4    = pc_plus4;
    assign bus.fetch_valid = (state_q == RUN) && !bus.stall && !reset;
    assign bus.halted      = halted_q;
    assign bus.trapped     = trapped_q;
    assign bus.fault_addr  = fault_addr_q;
    assign bus.instret     = instret_q;
endmodule
